div_seq_ctrl: RTL and testbench

DIV_SEQ_CTRL -- requirements
Module: div_seq_ctrl

---
 rtl/div_seq_ctrl.sv | 172 +++++++++++++++++
 tb/tb_div_seq_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : div_seq_ctrl
// Description : Sequencing controller for an iterative divider. Walks an
//               IDLE -> LOAD -> RUN (STEPS cycles) -> DONE sequence. A zero
//               divisor ends the operation early with an error. Abort cancels
//               the operation. One Start request that arrives while busy can
//               be held pending.
// Revision    : 1.0 - initial release
// ============================================================================
module div_seq_ctrl #(
    parameter int STEPS      = 8,   // iteration cycles per operation (1..255)
    parameter int EDGE_START = 1,   // 1: rising edge of Start, 0: level
    parameter int QUEUE_EN   = 1,   // 1: hold one request arriving while busy
    parameter int CW         = 8    // count width, 2**CW > STEPS
) (
    input  logic          Clk,
    input  logic          Reset,    // asynchronous, active low
    input  logic          Start,
    input  logic          Abort,
    input  logic          Zero,
    output logic          run,
    output logic          load,
    output logic          step_en,
    output logic [CW-1:0] count,
    output logic          done,
    output logic          err,
    output logic          busy,
    output logic          pend
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_LOAD = 2'd1;
    localparam logic [1:0] c_ST_RUN  = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    localparam logic [CW-1:0] c_LAST = CW'(STEPS - 1);

    logic [1:0]    r_state;
    logic [1:0]    w_next_state;
    logic [CW-1:0] r_count;
    logic          r_err;
    logic          r_pend;
    logic          w_start_evt;
    logic          w_abort;

    // Abort only matters while an operation is actually in LOAD or RUN
    assign w_abort = Abort && ((r_state == c_ST_LOAD) || (r_state == c_ST_RUN));

    generate
        if (EDGE_START != 0) begin : g_edge_start
            logic r_start_prev;

            // Previous Start resets high so a Start already asserted at
            // reset release must fall before it can trigger an operation
            always_ff @(posedge Clk or negedge Reset) begin
                if (!Reset) begin
                    r_start_prev <= 1'b1;
                end else begin
                    r_start_prev <= Start;
                end
            end

            assign w_start_evt = Start && !r_start_prev;
        end else begin : g_level_start
            assign w_start_evt = Start;
        end
    endgenerate

    // State register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; Abort outranks both Zero and the normal sequence
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_start_evt) begin
                    w_next_state = c_ST_LOAD;
                end
            end
            c_ST_LOAD: begin
                if (Abort) begin
                    w_next_state = c_ST_IDLE;
                end else if (Zero) begin
                    w_next_state = c_ST_DONE;
                end else begin
                    w_next_state = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (Abort) begin
                    w_next_state = c_ST_IDLE;
                end else if (r_count == c_LAST) begin
                    w_next_state = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                // A request arriving in DONE is consumed on the same edge
                if (r_pend || (w_start_evt && (QUEUE_EN != 0))) begin
                    w_next_state = c_ST_LOAD;
                end else begin
                    w_next_state = c_ST_IDLE;
                end
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    // Output decode from registered state only: no input-to-output path
    always_comb begin
        run     = (r_state == c_ST_LOAD) || (r_state == c_ST_RUN);
        load    = (r_state == c_ST_LOAD);
        step_en = (r_state == c_ST_RUN);
        done    = (r_state == c_ST_DONE);
        busy    = (r_state != c_ST_IDLE);
    end

    // Iteration counter: counts through RUN, zero everywhere else
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_count <= '0;
        end else if ((r_state == c_ST_RUN) && (w_next_state == c_ST_RUN)) begin
            r_count <= r_count + CW'(1);
        end else begin
            r_count <= '0;
        end
    end

    // Error flag: cleared when an operation loads, set on a zero-divisor exit
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_err <= 1'b0;
        end else if (w_next_state == c_ST_LOAD) begin
            r_err <= 1'b0;
        end else if ((r_state == c_ST_LOAD) && (w_next_state == c_ST_DONE)) begin
            r_err <= 1'b1;
        end
    end

    generate
        if (QUEUE_EN != 0) begin : g_queue
            // Pending request: set by a start event while busy, cleared by
            // abort or by the DONE cycle (which consumes it)
            always_ff @(posedge Clk or negedge Reset) begin
                if (!Reset) begin
                    r_pend <= 1'b0;
                end else if (w_abort || (r_state == c_ST_DONE)) begin
                    r_pend <= 1'b0;
                end else if (w_start_evt && (r_state != c_ST_IDLE)) begin
                    r_pend <= 1'b1;
                end
            end
        end else begin : g_no_queue
            assign r_pend = 1'b0;
        end
    endgenerate

    assign count = r_count;
    assign err   = r_err;
    assign pend  = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_div_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_seq_ctrl
// Description : Directed bench for div_seq_ctrl. The main instance uses the
//               default parameters. Two side instances (no queue, level start)
//               share the same stimulus. Expected completions are queued when a
//               start is driven and popped when done appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_seq_ctrl;

    localparam int STEPS = 8;
    localparam int CW    = 8;

    logic          Clk;
    logic          Reset;
    logic          Start;
    logic          Abort;
    logic          Zero;

    logic          run, load, step_en, done, err, busy, pend;
    logic [CW-1:0] count;

    logic          nq_run, nq_load, nq_step_en, nq_done, nq_err, nq_busy, nq_pend;
    logic [CW-1:0] nq_count;

    logic          lv_run, lv_load, lv_step_en, lv_done, lv_err, lv_busy, lv_pend;
    logic [CW-1:0] lv_count;

    div_seq_ctrl #(.STEPS(STEPS), .EDGE_START(1), .QUEUE_EN(1), .CW(CW)) u_dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Abort(Abort), .Zero(Zero),
        .run(run), .load(load), .step_en(step_en), .count(count),
        .done(done), .err(err), .busy(busy), .pend(pend)
    );

    div_seq_ctrl #(.STEPS(STEPS), .EDGE_START(1), .QUEUE_EN(0), .CW(CW)) u_dut_nq (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Abort(Abort), .Zero(Zero),
        .run(nq_run), .load(nq_load), .step_en(nq_step_en), .count(nq_count),
        .done(nq_done), .err(nq_err), .busy(nq_busy), .pend(nq_pend)
    );

    div_seq_ctrl #(.STEPS(STEPS), .EDGE_START(0), .QUEUE_EN(1), .CW(CW)) u_dut_lvl (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Abort(Abort), .Zero(Zero),
        .run(lv_run), .load(lv_load), .step_en(lv_step_en), .count(lv_count),
        .done(lv_done), .err(lv_err), .busy(lv_busy), .pend(lv_pend)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic err;
        int   due;
    } exp_t;

    exp_t sb[$];

    int checks     = 0;
    int errors     = 0;
    int cyc        = 0;
    int nq_dones   = 0;
    int lv_dones   = 0;
    int lv_reload  = 0;
    logic lv_done_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic expect_op(input logic e_err, input int due);
        exp_t e;
        e.err = e_err;
        e.due = due;
        sb.push_back(e);
    endtask

    // One clock: sample #1 after the edge, then score any completion
    task automatic step();
        exp_t e;
        @(posedge Clk);
        #1;
        cyc++;
        if (nq_done) nq_dones++;
        if (lv_load && lv_done_prev) lv_reload++;
        lv_done_prev = lv_done;
        if (lv_done) lv_dones++;
        if (done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", done, 1'b0);
            end else begin
                e = sb.pop_front();
                chk("done_cycle", cyc, e.due);
                chk("done_err", err, e.err);
            end
        end
    endtask

    task automatic wait_empty(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) step();
        chk("completion_timeout", sb.size(), 0);
    endtask

    task automatic do_reset();
        Start = 1'b0;
        Abort = 1'b0;
        Zero  = 1'b0;
        Reset = 1'b0;
        #3;
        Reset = 1'b1;
        step();
        step();
    endtask

    initial begin
        int   busy_cnt;
        int   first_due;
        Reset = 1'b0;
        Start = 1'b0;
        Abort = 1'b0;
        Zero  = 1'b0;

        // ---------------- reset state ----------------
        #12;
        chk("rst_busy", busy, 1'b0);
        chk("rst_run", run, 1'b0);
        chk("rst_load", load, 1'b0);
        chk("rst_step_en", step_en, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_pend", pend, 1'b0);
        chk("rst_count", count, 0);
        #1;
        Reset = 1'b1;
        step();
        step();

        // ---------------- normal operation ----------------
        Start = 1'b1;
        expect_op(1'b0, cyc + STEPS + 2);
        step();
        Start = 1'b0;
        chk("norm_load", load, 1'b1);
        chk("norm_run", run, 1'b1);
        chk("norm_busy", busy, 1'b1);
        chk("norm_load_count", count, 0);
        chk("norm_load_step", step_en, 1'b0);
        for (int i = 0; i < STEPS; i++) begin
            step();
            chk("norm_step_en", step_en, 1'b1);
            chk("norm_count", count, i);
            chk("norm_run_load", load, 1'b0);
        end
        step();
        chk("norm_done_seen", done, 1'b1);
        chk("norm_done_run", run, 1'b0);
        chk("norm_done_step", step_en, 1'b0);
        step();
        chk("norm_idle_busy", busy, 1'b0);
        chk("norm_idle_count", count, 0);

        // ---------------- divide by zero ----------------
        Zero  = 1'b1;
        Start = 1'b1;
        expect_op(1'b1, cyc + 2);
        step();
        Start = 1'b0;
        chk("zero_load", load, 1'b1);
        chk("zero_load_step", step_en, 1'b0);
        step();
        Zero = 1'b0;
        chk("zero_done_seen", done, 1'b1);
        chk("zero_done_step", step_en, 1'b0);
        step();
        chk("zero_idle_busy", busy, 1'b0);
        chk("zero_err_hold", err, 1'b1);

        // ---------------- abort in LOAD beats Zero ----------------
        Start = 1'b1;
        expect_op(1'b0, cyc + 2);
        step();
        Start = 1'b0;
        chk("abl_err_clear", err, 1'b0);
        Zero  = 1'b1;
        Abort = 1'b1;
        step();
        void'(sb.pop_back());
        Zero  = 1'b0;
        Abort = 1'b0;
        chk("abl_busy", busy, 1'b0);
        chk("abl_done", done, 1'b0);
        chk("abl_err", err, 1'b0);

        // ---------------- queued request ----------------
        do_reset();
        nq_dones = 0;
        Start = 1'b1;
        first_due = cyc + STEPS + 2;
        expect_op(1'b0, first_due);
        step();
        Start = 1'b0;
        for (int i = 0; i < 20 && !(step_en && count == 3); i++) step();
        chk("q_at_count3", count, 3);
        Start = 1'b1;
        expect_op(1'b0, first_due + STEPS + 2);
        step();
        Start = 1'b0;
        chk("q_pend_set", pend, 1'b1);
        chk("q_nq_pend", nq_pend, 1'b0);
        step();
        // further request while pending is dropped
        Start = 1'b1;
        step();
        Start = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            chk("q_pend_hold", pend, 1'b1);
            step();
        end
        chk("q_pend_in_done", pend, 1'b1);
        step();
        chk("q_load_after_done", load, 1'b1);
        chk("q_pend_cleared", pend, 1'b0);
        wait_empty(30);
        for (int i = 0; i < 15; i++) step();
        chk("q_nq_single_done", nq_dones, 1);

        // ---------------- abort in RUN ----------------
        do_reset();
        Start = 1'b1;
        expect_op(1'b0, cyc + STEPS + 2);
        step();
        Start = 1'b0;
        for (int i = 0; i < 20 && !(step_en && count == 5); i++) step();
        chk("ab_at_count5", count, 5);
        Abort = 1'b1;
        step();
        void'(sb.pop_back());
        Abort = 1'b0;
        chk("ab_busy", busy, 1'b0);
        chk("ab_count", count, 0);
        chk("ab_done", done, 1'b0);
        chk("ab_run", run, 1'b0);
        step();
        Start = 1'b1;
        expect_op(1'b0, cyc + STEPS + 2);
        step();
        Start = 1'b0;
        wait_empty(20);

        // ---------------- Start held 30 cycles ----------------
        do_reset();
        lv_dones     = 0;
        lv_reload    = 0;
        lv_done_prev = 1'b0;
        Start = 1'b1;
        expect_op(1'b0, cyc + STEPS + 2);
        for (int i = 0; i < 30; i++) step();
        Start = 1'b0;
        for (int i = 0; i < 15; i++) step();
        chk("hold_edge_single", sb.size(), 0);
        chk("hold_edge_idle", busy, 1'b0);
        chk("hold_lvl_dones", lv_dones, 4);
        chk("hold_lvl_reload", lv_reload, 3);

        // ---------------- async reset mid-RUN ----------------
        Start = 1'b1;
        expect_op(1'b0, cyc + STEPS + 2);
        step();
        Start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("ar_in_run", step_en, 1'b1);
        #3;
        Reset = 1'b0;
        #1;
        void'(sb.pop_back());
        chk("ar_busy", busy, 1'b0);
        chk("ar_run", run, 1'b0);
        chk("ar_step_en", step_en, 1'b0);
        chk("ar_count", count, 0);
        chk("ar_done", done, 1'b0);
        Start = 1'b1;
        #2;
        Reset = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (busy) busy_cnt++;
        end
        Start = 1'b0;
        chk("ar_no_start", busy_cnt, 0);
        step();

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
